regfile_sb: RTL

//  Parametrised register file for the single-cycle CPU and its pipelined follow-on: one write port, NUM_READ read ports.

---
 rtl/regfile_sb.sv | 88 ++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with scoreboard pending bits, write bypass and optional zero register
// One write port, NUM_READ combinational read ports, per-register pending bits set by RESERVE and cleared by WRITE.
module regfile_sb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_READ   = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [DATA_WIDTH-1:0]          IN,
  input  logic [ADDR_WIDTH-1:0]          INADDRESS,
  input  logic                           WRITE,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] OUTADDRESS,
  output logic [NUM_READ*DATA_WIDTH-1:0] OUT,
  output logic [NUM_READ-1:0]            OUTREADY,
  input  logic                           RESERVE,
  input  logic [ADDR_WIDTH-1:0]          RESADDRESS,
  output logic                           RES_STALL,
  output logic [ADDR_WIDTH:0]            PEND_COUNT
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      pend_q, pend_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  wr_en, res_acc, stall;
  logic [ADDR_WIDTH-1:0] ra;

  always_comb begin
    wr_en   = WRITE && !((ZERO_REG != 0) && (INADDRESS == '0));
    // A write to the same register this cycle releases it, so the reserve may proceed.
    stall   = RESERVE && pend_q[RESADDRESS] && !(WRITE && (INADDRESS == RESADDRESS));
    res_acc = RESERVE && !stall && !((ZERO_REG != 0) && (RESADDRESS == '0));
    pend_d  = pend_q;
    if (wr_en) begin
      pend_d[INADDRESS] = 1'b0;
    end
    if (res_acc) begin
      pend_d[RESADDRESS] = 1'b1;
    end
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + {{ADDR_WIDTH{1'b0}}, pend_d[i]};
    end
  end

  always_comb begin
    OUT      = '0;
    OUTREADY = '0;
    ra       = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      ra = OUTADDRESS[k*ADDR_WIDTH +: ADDR_WIDTH];
      if ((ZERO_REG != 0) && (ra == '0)) begin
        OUT[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        OUTREADY[k]                     = 1'b1;
      end else if ((BYPASS != 0) && WRITE && (INADDRESS == ra)) begin
        OUT[k*DATA_WIDTH +: DATA_WIDTH] = IN;
        OUTREADY[k]                     = 1'b1;
      end else begin
        OUT[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[ra];
        OUTREADY[k]                     = !pend_q[ra];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) begin
        regs_q[INADDRESS] <= IN;
      end
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign RES_STALL  = stall;
  assign PEND_COUNT = cnt_q;

endmodule
